// File: rtl/boxlambda_reset_pkg.sv
// -----------------------------------------------------------------------------
// boxlambda_reset_pkg
// Shared definitions for the BoxLambda reset sequencer:
//   - reset_state_t : sequencer state encoding
//   - RSN_*         : bit positions inside the sticky reset-reason register
//   - max3()        : constant helper used to size the shared phase counter
// -----------------------------------------------------------------------------
package boxlambda_reset_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_PLL  = 3'd0,  // all resets held, waiting for a stable PLL lock
      ST_HOLD      = 3'd1,  // all resets held for a fixed number of cycles
      ST_DRAM_INIT = 3'd2,  // dm/dram released, waiting for DRAM calibration
      ST_RUN       = 3'd3,  // everything released
      ST_NDM_HOLD  = 3'd4   // non-debug domain re-reset on request
   } reset_state_t;

   // Reset-reason bit positions.
   localparam int RSN_POR = 0;  // external / power-on reset
   localparam int RSN_PLL = 1;  // PLL lock lost
   localparam int RSN_DBG = 2;  // debugger ndm reset request
   localparam int RSN_SW  = 3;  // software reset request

   localparam int          RSN_W        = 4;
   localparam logic [3:0]  REASON_RESET = 4'b0001;

   // Largest of three cycle counts; sizes the single shared down-counter.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

endpackage : boxlambda_reset_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous level (the PLL lock).
// Both flops clear to 0 on reset, so the synchronised level reads "not
// locked" until the input has been seen high for two clock edges.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input level
//   q     : synchronised level (2 cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : sync_2ff

// File: rtl/boxlambda_reset_ctrl.sv
// -----------------------------------------------------------------------------
// boxlambda_reset_ctrl
// Reset sequencer for the BoxLambda SoC. Orders the reset releases of the
// debug module, the DRAM controller and the non-debug domain, waits for PLL
// lock and DRAM calibration, and re-runs the non-debug reset on debugger or
// software request. Any loss of PLL lock restarts the whole sequence.
//
// Ports
//   clk              : system clock
//   rst_n            : asynchronous active-low reset
//   pll_locked_i     : PLL lock (asynchronous, synchronised internally)
//   ndm_reset_req_i  : debugger non-debug reset request (level, edge-detected)
//   sw_reset_req_i   : software reset request (single-cycle pulse)
//   dram_init_done_i : DRAM calibration complete
//   dram_init_err_i  : DRAM calibration failed
//   reason_clr_i     : pulse, clears reset_reason_o
//   dm_rst_n_o       : debug-module reset, active-low
//   dram_rst_n_o     : DRAM controller reset, active-low
//   ndm_rst_n_o      : non-debug domain reset, active-low
//   ndm_reset_ack_o  : one-cycle pulse when a debugger-requested reset ends
//   init_done_o      : sequence complete (init_done LED)
//   init_err_o       : sticky DRAM error/timeout (init_err LED)
//   reset_reason_o   : sticky cause bits {sw, dbg, pll, por}
//
// All outputs are registered and decoded from the present state, so they
// follow a state transition by exactly one cycle.
// -----------------------------------------------------------------------------
module boxlambda_reset_ctrl
   import boxlambda_reset_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYCLES  = 64,
   parameter int unsigned RST_HOLD_CYCLES     = 16,
   parameter bit          DRAM_ACTIVE         = 1'b1,
   parameter int unsigned DRAM_TIMEOUT_CYCLES = 2**24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_locked_i,
   input  logic             ndm_reset_req_i,
   input  logic             sw_reset_req_i,
   input  logic             dram_init_done_i,
   input  logic             dram_init_err_i,
   input  logic             reason_clr_i,
   output logic             dm_rst_n_o,
   output logic             dram_rst_n_o,
   output logic             ndm_rst_n_o,
   output logic             ndm_reset_ack_o,
   output logic             init_done_o,
   output logic             init_err_o,
   output logic [RSN_W-1:0] reset_reason_o
);

   // ---------------------------------------------------------------------------
   // Shared phase counter sizing
   // ---------------------------------------------------------------------------
   localparam int unsigned CNT_MAX = max3(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES,
                                          DRAM_TIMEOUT_CYCLES);
   localparam int          CNT_W   = $clog2(CNT_MAX + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t LOCK_LOAD = cnt_t'(LOCK_STABLE_CYCLES);
   localparam cnt_t HOLD_LOAD = cnt_t'(RST_HOLD_CYCLES);
   localparam cnt_t DRAM_LOAD = cnt_t'(DRAM_TIMEOUT_CYCLES);

   // Reload value for the phase being entered. ST_RUN does not time
   // anything, so it shares the hold value harmlessly.
   function automatic cnt_t load_for(input reset_state_t s);
      cnt_t v;
      case (s)
         ST_WAIT_PLL:  v = LOCK_LOAD;
         ST_DRAM_INIT: v = DRAM_LOAD;
         default:      v = HOLD_LOAD;
      endcase
      return v;
   endfunction

   // ---------------------------------------------------------------------------
   // Signals
   // ---------------------------------------------------------------------------
   logic             lock_s;      // synchronised PLL lock
   reset_state_t     state;
   reset_state_t     state_next;
   cnt_t             cnt;
   cnt_t             cnt_next;
   logic             expired;     // current phase has used up its cycle budget
   logic             req_q;       // previous ndm_reset_req_i, for edge detect
   logic             req_rise;
   logic             dbg_q;       // current ndm hold was debugger-initiated
   logic             dbg_next;
   logic [RSN_W-1:0] reason_q;
   logic [RSN_W-1:0] reason_set;
   logic             err_q;
   logic             err_set;
   logic             ack_q;
   logic             ack_set;

   // ---------------------------------------------------------------------------
   // PLL lock synchroniser
   // ---------------------------------------------------------------------------
   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_locked_i),
      .q     (lock_s)
   );

   assign req_rise = ndm_reset_req_i && !req_q;

   // A count of 1 means this is the last cycle of the phase; 0 only occurs
   // for zero-length parameters and is treated the same way.
   assign expired = (cnt <= cnt_t'(1));

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch can
      // leave one unassigned and infer a latch.
      state_next = state;
      cnt_next   = (cnt != '0) ? cnt - cnt_t'(1) : '0;  // saturate, never wrap
      reason_set = '0;
      err_set    = 1'b0;
      ack_set    = 1'b0;
      dbg_next   = dbg_q;

      // Lost lock outranks everything else in every state but the lock wait.
      if (state != ST_WAIT_PLL && !lock_s) begin
         state_next          = ST_WAIT_PLL;
         reason_set[RSN_PLL] = 1'b1;
      end else begin
         case (state)
            ST_WAIT_PLL: begin
               if (!lock_s) begin
                  cnt_next = LOCK_LOAD;  // any low cycle restarts the count
               end else if (expired) begin
                  state_next = ST_HOLD;
               end
            end

            ST_HOLD: begin
               if (expired) begin
                  state_next = DRAM_ACTIVE ? ST_DRAM_INIT : ST_RUN;
               end
            end

            ST_DRAM_INIT: begin
               // Error wins over done; both end the phase.
               if (dram_init_err_i) begin
                  err_set    = 1'b1;
                  state_next = ST_RUN;
               end else if (dram_init_done_i) begin
                  state_next = ST_RUN;
               end else if (expired) begin
                  err_set    = 1'b1;
                  state_next = ST_RUN;
               end
            end

            ST_RUN: begin
               if (req_rise || sw_reset_req_i) begin
                  reason_set[RSN_DBG] = req_rise;
                  reason_set[RSN_SW]  = sw_reset_req_i;
                  dbg_next            = req_rise;
                  state_next          = ST_NDM_HOLD;
               end
            end

            ST_NDM_HOLD: begin
               // Requests are ignored here; only the hold length matters.
               if (expired) begin
                  state_next = ST_RUN;
                  ack_set    = dbg_q;
               end
            end

            default: begin
               state_next = ST_WAIT_PLL;
            end
         endcase
      end

      if (state_next != state) begin
         cnt_next = load_for(state_next);
      end
   end

   // ---------------------------------------------------------------------------
   // State, bookkeeping and registered outputs
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side below sees the value from before this clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_WAIT_PLL;
         cnt             <= LOCK_LOAD;
         req_q           <= 1'b0;
         dbg_q           <= 1'b0;
         reason_q        <= REASON_RESET;
         err_q           <= 1'b0;
         ack_q           <= 1'b0;
         dm_rst_n_o      <= 1'b0;
         dram_rst_n_o    <= 1'b0;
         ndm_rst_n_o     <= 1'b0;
         ndm_reset_ack_o <= 1'b0;
         init_done_o     <= 1'b0;
         init_err_o      <= 1'b0;
         reset_reason_o  <= REASON_RESET;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         req_q    <= ndm_reset_req_i;
         dbg_q    <= dbg_next;
         // A clear and a set in the same cycle: the set wins for that bit.
         reason_q <= (reason_clr_i ? '0 : reason_q) | reason_set;
         err_q    <= err_q | err_set;  // cleared only by rst_n
         ack_q    <= ack_set;

         // Outputs decode the present state, one cycle behind the transition.
         dm_rst_n_o      <= (state inside {ST_DRAM_INIT, ST_RUN, ST_NDM_HOLD});
         dram_rst_n_o    <= (state inside {ST_DRAM_INIT, ST_RUN, ST_NDM_HOLD});
         ndm_rst_n_o     <= (state == ST_RUN);
         init_done_o     <= (state inside {ST_RUN, ST_NDM_HOLD});
         ndm_reset_ack_o <= ack_q;
         init_err_o      <= err_q;
         reset_reason_o  <= reason_q;
      end
   end

endmodule : boxlambda_reset_ctrl

// File: tb/tb_boxlambda_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boxlambda_reset_ctrl
// Self-checking bench: directed scenarios with hand-computed expectations,
// followed by randomized stimulus checked every cycle against a behavioural
// model that tracks phases by absolute cycle stamps.
// A second instance (short timings, no DRAM phase, lock tied high) pins the
// minimum release latency.
// -----------------------------------------------------------------------------
module tb_boxlambda_reset_ctrl;

   localparam int unsigned L  = 64;
   localparam int unsigned H  = 16;
   localparam int unsigned T  = 100;
   localparam bit          DA = 1'b1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pll_locked_i = 1'b0;
   logic ndm_reset_req_i = 1'b0;
   logic sw_reset_req_i = 1'b0;
   logic dram_init_done_i = 1'b0;
   logic dram_init_err_i = 1'b0;
   logic reason_clr_i = 1'b0;

   logic       dm_rst_n_o, dram_rst_n_o, ndm_rst_n_o, ndm_reset_ack_o;
   logic       init_done_o, init_err_o;
   logic [3:0] reset_reason_o;

   logic       nd_dm, nd_dram, nd_ndm, nd_ack, nd_done, nd_err;
   logic [3:0] nd_reason;

   always #5 clk = ~clk;

   boxlambda_reset_ctrl #(
      .LOCK_STABLE_CYCLES  (L),
      .RST_HOLD_CYCLES     (H),
      .DRAM_ACTIVE         (DA),
      .DRAM_TIMEOUT_CYCLES (T)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pll_locked_i     (pll_locked_i),
      .ndm_reset_req_i  (ndm_reset_req_i),
      .sw_reset_req_i   (sw_reset_req_i),
      .dram_init_done_i (dram_init_done_i),
      .dram_init_err_i  (dram_init_err_i),
      .reason_clr_i     (reason_clr_i),
      .dm_rst_n_o       (dm_rst_n_o),
      .dram_rst_n_o     (dram_rst_n_o),
      .ndm_rst_n_o      (ndm_rst_n_o),
      .ndm_reset_ack_o  (ndm_reset_ack_o),
      .init_done_o      (init_done_o),
      .init_err_o       (init_err_o),
      .reset_reason_o   (reset_reason_o)
   );

   boxlambda_reset_ctrl #(
      .LOCK_STABLE_CYCLES  (8),
      .RST_HOLD_CYCLES     (4),
      .DRAM_ACTIVE         (1'b0),
      .DRAM_TIMEOUT_CYCLES (100)
   ) dut_nd (
      .clk              (clk),
      .rst_n            (rst_n),
      .pll_locked_i     (1'b1),
      .ndm_reset_req_i  (1'b0),
      .sw_reset_req_i   (1'b0),
      .dram_init_done_i (1'b0),
      .dram_init_err_i  (1'b0),
      .reason_clr_i     (1'b0),
      .dm_rst_n_o       (nd_dm),
      .dram_rst_n_o     (nd_dram),
      .ndm_rst_n_o      (nd_ndm),
      .ndm_reset_ack_o  (nd_ack),
      .init_done_o      (nd_done),
      .init_err_o       (nd_err),
      .reset_reason_o   (nd_reason)
   );

   // ---------------------------------------------------------------------------
   // Check bookkeeping
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: phases with absolute end-cycle stamps. Outputs shown
   // after an edge reflect the phase held before that edge.
   // ---------------------------------------------------------------------------
   localparam int P_WAIT = 0, P_HOLD = 1, P_DRAM = 2, P_RUN = 3, P_NDM = 4;

   int          m_phase    = P_WAIT;
   longint      m_cyc      = 0;
   longint      m_end      = 0;
   int unsigned m_run      = 0;
   bit [1:0]    m_sync     = '0;   // pll samples from one and two edges ago
   bit          m_req_prev = 1'b0;
   bit          m_dbg      = 1'b0;
   bit          m_ack      = 1'b0;
   bit          m_err      = 1'b0;
   bit [3:0]    m_reason   = 4'b0001;

   bit       exp_dm = 1'b0, exp_dram = 1'b0, exp_ndm = 1'b0, exp_ack = 1'b0;
   bit       exp_done = 1'b0, exp_err = 1'b0;
   bit [3:0] exp_reason = 4'b0001;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = P_WAIT; m_run = 0; m_sync = '0; m_req_prev = 1'b0;
         m_dbg = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_reason = 4'b0001;
         exp_dm = 1'b0; exp_dram = 1'b0; exp_ndm = 1'b0; exp_ack = 1'b0;
         exp_done = 1'b0; exp_err = 1'b0; exp_reason = 4'b0001;
      end else begin
         bit       lock;
         bit       rise;
         bit [3:0] nr;
         exp_dm     = (m_phase == P_DRAM || m_phase == P_RUN || m_phase == P_NDM);
         exp_dram   = exp_dm;
         exp_ndm    = (m_phase == P_RUN);
         exp_done   = (m_phase == P_RUN || m_phase == P_NDM);
         exp_ack    = m_ack;
         exp_err    = m_err;
         exp_reason = m_reason;

         m_cyc++;
         lock       = m_sync[1];
         m_sync     = {m_sync[0], pll_locked_i};
         rise       = ndm_reset_req_i && !m_req_prev;
         m_req_prev = ndm_reset_req_i;
         nr         = reason_clr_i ? 4'b0000 : m_reason;
         m_ack      = 1'b0;

         if (m_phase != P_WAIT && !lock) begin
            nr[1] = 1'b1; m_phase = P_WAIT; m_run = 0;
         end else begin
            case (m_phase)
               P_WAIT: begin
                  if (lock) begin
                     m_run++;
                     if (m_run >= L) begin m_phase = P_HOLD; m_end = m_cyc + H; end
                  end else m_run = 0;
               end
               P_HOLD: if (m_cyc == m_end) begin
                  if (DA) begin m_phase = P_DRAM; m_end = m_cyc + T; end
                  else m_phase = P_RUN;
               end
               P_DRAM: begin
                  if (dram_init_err_i) begin m_err = 1'b1; m_phase = P_RUN; end
                  else if (dram_init_done_i) m_phase = P_RUN;
                  else if (m_cyc == m_end) begin m_err = 1'b1; m_phase = P_RUN; end
               end
               P_RUN: if (rise || sw_reset_req_i) begin
                  if (rise) nr[2] = 1'b1;
                  if (sw_reset_req_i) nr[3] = 1'b1;
                  m_dbg = rise; m_phase = P_NDM; m_end = m_cyc + H;
               end
               default: if (m_cyc == m_end) begin m_phase = P_RUN; m_ack = m_dbg; end
            endcase
         end
         m_reason = nr;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("mdl_dm_rst_n",   32'(dm_rst_n_o),      32'(exp_dm));
         check("mdl_dram_rst_n", 32'(dram_rst_n_o),    32'(exp_dram));
         check("mdl_ndm_rst_n",  32'(ndm_rst_n_o),     32'(exp_ndm));
         check("mdl_ack",        32'(ndm_reset_ack_o), 32'(exp_ack));
         check("mdl_init_done",  32'(init_done_o),     32'(exp_done));
         check("mdl_init_err",   32'(init_err_o),      32'(exp_err));
         check("mdl_reason",     32'(reset_reason_o),  32'(exp_reason));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      bit seen;
      int lows, acks, fall_at, rise_at, ack_at, dm_lows;
      int pll_low_left, rst_left;

      // Reset values.
      repeat (3) @(negedge clk);
      check("rst_dm",      32'(dm_rst_n_o),      32'd0);
      check("rst_dram",    32'(dram_rst_n_o),    32'd0);
      check("rst_ndm",     32'(ndm_rst_n_o),     32'd0);
      check("rst_ack",     32'(ndm_reset_ack_o), 32'd0);
      check("rst_done",    32'(init_done_o),     32'd0);
      check("rst_err",     32'(init_err_o),      32'd0);
      check("rst_reason",  32'(reset_reason_o),  32'h1);
      check("nd_rst_ndm",  32'(nd_ndm),          32'd0);
      check("nd_rst_rsn",  32'(nd_reason),       32'h1);
      cmp_en = 1'b1;
      rst_n  = 1'b1;

      // Power-up: lock at cycle 10, DRAM done 20 cycles after its release.
      seen = 1'b0;
      for (int j = 1; j <= 300 && !seen; j++) begin
         @(negedge clk);
         if (j == 10) pll_locked_i = 1'b1;
         if (j == 14) check("nd_ndm_before_min", 32'(nd_ndm), 32'd0);
         if (j == 15) check("nd_ndm_at_min",     32'(nd_ndm), 32'd1);
         if (dram_rst_n_o) begin
            seen = 1'b1;
            check("t1_dram_release_cycle", j, 32'd93);
            check("t1_ndm_still_held", 32'(ndm_rst_n_o), 32'd0);
         end
      end
      check("t1_dram_release_seen", 32'(seen), 32'd1);
      repeat (20) @(negedge clk);
      dram_init_done_i = 1'b1;
      @(negedge clk);
      dram_init_done_i = 1'b0;
      check("t1_ndm_not_yet", 32'(ndm_rst_n_o), 32'd0);
      @(negedge clk);
      check("t1_ndm_released", 32'(ndm_rst_n_o), 32'd1);
      check("t1_init_done",    32'(init_done_o), 32'd1);
      check("t1_reason",       32'(reset_reason_o), 32'h1);
      check("t1_init_err",     32'(init_err_o), 32'd0);

      // Debugger + software request together; repeat requests inside hold.
      repeat (3) @(negedge clk);
      ndm_reset_req_i = 1'b1;
      sw_reset_req_i  = 1'b1;
      lows = 0; acks = 0; fall_at = -1; rise_at = -1; ack_at = -1; dm_lows = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) sw_reset_req_i = 1'b0;
         if (i == 5) ndm_reset_req_i = 1'b0;
         if (i == 8) begin ndm_reset_req_i = 1'b1; sw_reset_req_i = 1'b1; end
         if (i == 9) sw_reset_req_i = 1'b0;
         if (!ndm_rst_n_o) begin lows++; if (fall_at < 0) fall_at = i; end
         else if (fall_at >= 0 && rise_at < 0) rise_at = i;
         if (ndm_reset_ack_o) begin acks++; ack_at = i; end
         if (!dm_rst_n_o) dm_lows++;
      end
      ndm_reset_req_i = 1'b0;
      check("t3_ndm_fall_cycle", fall_at, 32'd2);
      check("t3_ndm_low_cycles", lows, 32'd16);
      check("t3_ack_count",      acks, 32'd1);
      check("t3_ack_with_rise",  ack_at, rise_at);
      check("t3_dm_stays_up",    dm_lows, 32'd0);
      check("t3_reason",         32'(reset_reason_o), 32'hD);

      // PLL loss in RUN coinciding with a reason clear.
      repeat (3) @(negedge clk);
      pll_locked_i = 1'b0;
      repeat (2) @(negedge clk);
      reason_clr_i = 1'b1;
      @(negedge clk);
      reason_clr_i = 1'b0;
      check("t5_still_running", 32'(ndm_rst_n_o), 32'd1);
      @(negedge clk);
      check("t5_dm",     32'(dm_rst_n_o),   32'd0);
      check("t5_dram",   32'(dram_rst_n_o), 32'd0);
      check("t5_ndm",    32'(ndm_rst_n_o),  32'd0);
      check("t5_done",   32'(init_done_o),  32'd0);
      check("t5_reason", 32'(reset_reason_o), 32'h2);

      // Relock with a one-cycle glitch at stable count 63.
      repeat (3) @(negedge clk);
      pll_locked_i = 1'b1;
      seen = 1'b0;
      for (int j = 1; j <= 400 && !seen; j++) begin
         @(negedge clk);
         if (j == 63) pll_locked_i = 1'b0;
         if (j == 64) pll_locked_i = 1'b1;
         if (dm_rst_n_o) begin
            seen = 1'b1;
            check("t2_dm_release_cycle", j, 32'd147);
         end
      end
      check("t2_dm_release_seen", 32'(seen), 32'd1);

      // DRAM done and error in the same cycle.
      dram_init_done_i = 1'b1;
      dram_init_err_i  = 1'b1;
      @(negedge clk);
      dram_init_done_i = 1'b0;
      dram_init_err_i  = 1'b0;
      @(negedge clk);
      check("t4_ndm_released", 32'(ndm_rst_n_o), 32'd1);
      check("t4_init_err",     32'(init_err_o),  32'd1);
      check("t4_init_done",    32'(init_done_o), 32'd1);

      // Asynchronous reset in the middle of an ndm hold.
      repeat (2) @(negedge clk);
      sw_reset_req_i = 1'b1;
      @(negedge clk);
      sw_reset_req_i = 1'b0;
      repeat (5) @(negedge clk);
      check("t6_in_hold", 32'(ndm_rst_n_o), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_dm",     32'(dm_rst_n_o),      32'd0);
      check("t6_dram",   32'(dram_rst_n_o),    32'd0);
      check("t6_ndm",    32'(ndm_rst_n_o),     32'd0);
      check("t6_ack",    32'(ndm_reset_ack_o), 32'd0);
      check("t6_done",   32'(init_done_o),     32'd0);
      check("t6_err",    32'(init_err_o),      32'd0);
      check("t6_reason", 32'(reset_reason_o),  32'h1);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against the model.
      pll_low_left = 0;
      rst_left     = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) rst_n = 1'b1;
         end
         if (pll_low_left > 0) begin
            pll_low_left--;
            pll_locked_i = 1'b0;
         end else if ($urandom_range(0, 499) == 0) begin
            pll_low_left = $urandom_range(1, 6);
            pll_locked_i = 1'b0;
         end else begin
            pll_locked_i = 1'b1;
         end
         if ($urandom_range(0, 29) == 0) ndm_reset_req_i = ~ndm_reset_req_i;
         sw_reset_req_i   = ($urandom_range(0, 39) == 0);
         dram_init_done_i = ($urandom_range(0, 79) == 0);
         dram_init_err_i  = ($urandom_range(0, 199) == 0);
         reason_clr_i     = ($urandom_range(0, 49) == 0);
         if (rst_left == 0 && rst_n && $urandom_range(0, 1499) == 0) begin
            rst_left = 2;
            #2 rst_n = 1'b0;
         end
      end
      @(negedge clk);
      cmp_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_boxlambda_reset_ctrl
